// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO card-side command/response path.
package sdio_pkg;

  typedef enum logic [1:0] {
    R1 = 2'd0,
    R3 = 2'd1,
    R7 = 2'd2
  } resp_type_e;

  localparam int         SDIO_FRAME_LEN = 48;
  localparam logic [6:0] SDIO_CRC7_POLY = 7'h09;
  localparam int         SDIO_NCR_MIN   = 2;
  localparam logic [5:0] R3_INDEX       = 6'h3F;
  localparam logic [6:0] R3_CRC         = 7'h7F;

  // One serial CRC7 step, MSB-first, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SDIO_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 engine; also shared with the command decoder's receive check.
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic       sd_clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc7_step(crc_q, din);
    end
  end

  always_ff @(posedge sd_clk) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sdio_resp_tx.sv
// Card-side SDIO response transmitter: NCR gap, then a 48-bit CRC7-protected frame on CMD.
// Build option SDIO_RESP_PREAMBLE_EN drives the line high for one cycle before the start bit.
module sdio_resp_tx
  import sdio_pkg::*;
#(
  parameter int NCR_CYCLES = 2,
  parameter int FRAME_LEN  = SDIO_FRAME_LEN
) (
  input  logic        sd_clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_index,
  input  logic [31:0] req_arg,
  input  logic [1:0]  req_type,
  input  logic        abort,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        resp_done
);

  localparam int         NCR_EFF   = (NCR_CYCLES < SDIO_NCR_MIN) ? SDIO_NCR_MIN : NCR_CYCLES;
  localparam logic [5:0] WAIT_INIT = 6'(NCR_EFF - 1);
  localparam logic [5:0] BIT_TOP   = 6'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
`ifdef SDIO_RESP_PREAMBLE_EN
    S_PRE   = 2'd3,
`endif
    S_SHIFT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  wait_cnt_q, wait_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] hdr_q, hdr_d;
  logic        r3_q, r3_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        launch;
  logic        crc_clr, crc_en, crc_din;
  logic [6:0]  crc_val;

  sdio_crc7 u_crc (
    .sd_clk (sd_clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .din    (crc_din),
    .crc    (crc_val)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    hdr_d      = hdr_q;
    r3_d       = r3_q;
    out_d      = out_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    launch     = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        oe_d    = 1'b0;
        out_d   = 1'b1;
        // An abort coinciding with the handshake drops the request.
        if (req_valid && ready_q && !abort) begin
          state_d    = S_WAIT;
          ready_d    = 1'b0;
          wait_cnt_d = WAIT_INIT;
          r3_d       = (req_type == R3);
          hdr_d      = {2'b00, (req_type == R3) ? R3_INDEX : req_index, req_arg};
          crc_clr    = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          out_d   = 1'b1;
          ready_d = 1'b1;
        end else if (wait_cnt_q == 6'd0) begin
`ifdef SDIO_RESP_PREAMBLE_EN
          state_d = S_PRE;
          oe_d    = 1'b1;
          out_d   = 1'b1;
`else
          state_d   = S_SHIFT;
          oe_d      = 1'b1;
          bit_cnt_d = BIT_TOP;
          launch    = 1'b1;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q - 6'd1;
        end
      end
`ifdef SDIO_RESP_PREAMBLE_EN
      S_PRE: begin
        if (abort) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          out_d   = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d   = S_SHIFT;
          oe_d      = 1'b1;
          bit_cnt_d = BIT_TOP;
          launch    = 1'b1;
        end
      end
`endif
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          out_d   = 1'b1;
          ready_d = 1'b1;
        end else if (bit_cnt_q == 6'd0) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          out_d   = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
          launch    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pick the bit launched at this edge; header bits also feed the CRC as they leave.
    if (launch) begin
      if (bit_cnt_d >= 6'd8) begin
        out_d   = hdr_q[bit_cnt_d - 6'd8];
        crc_en  = 1'b1;
        crc_din = out_d;
      end else if (bit_cnt_d != 6'd0) begin
        out_d = r3_q ? R3_CRC[3'(bit_cnt_d - 6'd1)] : crc_val[3'(bit_cnt_d - 6'd1)];
      end else begin
        out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sd_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
      hdr_q      <= '0;
      r3_q       <= 1'b0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hdr_q      <= hdr_d;
      r3_q       <= r3_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign sd_cmd_out = out_q;
  assign sd_cmd_oe  = oe_q;
  assign resp_done  = done_q;

endmodule
